// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode next-address sequencer (IDLE/EXEC/HALT)
// Optional micro-return stack enabled by defining USTACK_EN.
module microcode_sequencer #(
    parameter int UADDR_W     = 9,
    parameter int OPC_W       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               instr_valid,
    input  logic [2:0]         seq_op,
    input  logic [UADDR_W-1:0] seq_target,
    input  logic               flag_z,
    input  logic               flag_n,
    output logic [UADDR_W-1:0] uaddr,
    output logic               ir_load,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALT} state_t;

    localparam logic [2:0] OP_NEXT  = 3'b000;
    localparam logic [2:0] OP_JUMP  = 3'b001;
    localparam logic [2:0] OP_BRZ   = 3'b010;
    localparam logic [2:0] OP_BRN   = 3'b011;
    localparam logic [2:0] OP_FETCH = 3'b100;
    localparam logic [2:0] OP_CALL  = 3'b101;
    localparam logic [2:0] OP_RET   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t               state, state_nxt;
    logic [UADDR_W-1:0]   uaddr_nxt;
    logic [UADDR_W-1:0]   uaddr_inc;
    logic [UADDR_W-1:0]   dispatch_addr;
    logic                 err_nxt;

    assign uaddr_inc     = uaddr + 1'b1;
    assign dispatch_addr = UADDR_W'({1'b1, opcode, 4'b0000});
    assign ir_load       = !rst && (state == S_IDLE) && instr_valid;

`ifdef USTACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [UADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]    sp;
    logic               push, pop;
    logic               full, empty;
    logic [IDX_W-1:0]   top_idx, push_idx;

    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign empty    = (sp == '0);
    assign top_idx  = IDX_W'(sp - 1'b1);
    assign push_idx = IDX_W'(sp);

    // Contents are never cleared; resetting sp is enough to discard them.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push) begin
            stack_mem[push_idx] <= uaddr_inc;
            sp                  <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^STACK_DEPTH;
`endif

    always_comb begin
        state_nxt = state;
        uaddr_nxt = uaddr;
        err_nxt   = err;
`ifdef USTACK_EN
        push      = 1'b0;
        pop       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                uaddr_nxt = '0;
                if (instr_valid) begin
                    state_nxt = S_EXEC;
                    uaddr_nxt = dispatch_addr;
                end
            end
            S_EXEC: begin
                case (seq_op)
                    OP_NEXT:  uaddr_nxt = uaddr_inc;
                    OP_JUMP:  uaddr_nxt = seq_target;
                    OP_BRZ:   uaddr_nxt = flag_z ? seq_target : uaddr_inc;
                    OP_BRN:   uaddr_nxt = flag_n ? seq_target : uaddr_inc;
                    OP_FETCH: begin
                        uaddr_nxt = '0;
                        state_nxt = S_IDLE;
                    end
                    OP_CALL: begin
`ifdef USTACK_EN
                        if (full) begin
                            err_nxt   = 1'b1;
                            state_nxt = S_HALT;
                        end else begin
                            push      = 1'b1;
                            uaddr_nxt = seq_target;
                        end
`else
                        err_nxt   = 1'b1;
                        state_nxt = S_HALT;
`endif
                    end
                    OP_RET: begin
`ifdef USTACK_EN
                        if (empty) begin
                            err_nxt   = 1'b1;
                            state_nxt = S_HALT;
                        end else begin
                            pop       = 1'b1;
                            uaddr_nxt = stack_mem[top_idx];
                        end
`else
                        err_nxt   = 1'b1;
                        state_nxt = S_HALT;
`endif
                    end
                    OP_HALT:  state_nxt = S_HALT;
                    default:  state_nxt = S_HALT;
                endcase
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            uaddr  <= '0;
            busy   <= 1'b0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            uaddr  <= uaddr_nxt;
            busy   <= (state_nxt == S_EXEC);
            halted <= (state_nxt == S_HALT);
            err    <= err_nxt;
        end
    end

endmodule
